// File: rtl/servo_pkg.sv
// Shared constants and state encoding for the servo request sequencer and PWM stage.
package servo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      OPEN  = 2'd2,
      CLOSE = 2'd3
   } state_e;

   localparam int PW_W         = 21;
   localparam int PEND_W       = 4;
   localparam int CLK_HZ       = 100_000_000;
   localparam int FRAME_CYCLES = 2_000_000;
   localparam int CLOSED_W_DEF = 150_000;
   localparam int OPEN_W_DEF   = 60_000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/servo_seq_if.sv
// Request/abort/frame inputs and pulse-width/status outputs of the servo sequencer.
interface servo_seq_if;
   import servo_pkg::*;

   logic              req;
   logic              cancel;
   logic              frame_tick;
   logic [PW_W-1:0]   pulse_width;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              done;
   logic              overflow;

   modport master (
      output req, cancel, frame_tick,
      input  pulse_width, busy, pending, done, overflow
   );

   modport slave (
      input  req, cancel, frame_tick,
      output pulse_width, busy, pending, done, overflow
   );

endinterface

// File: rtl/servo_seq_sat_counter.sv
// Up/down counter saturating at MAX with a clear input and a sticky overflow flag.
module sat_counter #(
   parameter int W   = 4,
   parameter int MAX = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         ovf_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         ovf_q, ovf_d;

   // Clear wins; simultaneous inc and dec cancel out; overflow survives clear.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i) begin
         if (cnt_q == W'(MAX)) ovf_d = 1'b1;
         else                  cnt_d = cnt_q + W'(1);
      end else if (dec_i && !inc_i && cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/servo_seq.sv
// Servo request sequencer: queues dispense requests and steps the PWM high time
// through open/hold/close/settle, changing width only on PWM frame boundaries.
module servo_seq
   import servo_pkg::*;
#(
   parameter int CLOSED_W     = CLOSED_W_DEF,
   parameter int OPEN_W       = OPEN_W_DEF,
   parameter int OPEN_FRAMES  = 50,
   parameter int CLOSE_FRAMES = 25,
   parameter int MAX_PEND     = 15
) (
   input  logic  clk,
   input  logic  rst,
   servo_seq_if.slave bus
);

   localparam int CNT_W = $clog2(max2(OPEN_FRAMES, CLOSE_FRAMES));
   localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_FRAMES - 1);
   localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_FRAMES - 1);
   localparam logic [PW_W-1:0]  PW_CLOSED  = PW_W'(CLOSED_W);
   localparam logic [PW_W-1:0]  PW_OPEN    = PW_W'(OPEN_W);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PW_W-1:0]   pw_q, pw_d;
   logic              abort_q, abort_d;
   logic              done_q, done_d;
   logic              dec;
   logic [PEND_W-1:0] pend;
   logic              ovf;

   sat_counter #(.W(PEND_W), .MAX(MAX_PEND)) u_pend (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.cancel),
      .inc_i (bus.req & ~bus.cancel),
      .dec_i (dec),
      .cnt_o (pend),
      .ovf_o (ovf)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pw_d    = pw_q;
      abort_d = abort_q;
      done_d  = 1'b0;
      dec     = 1'b0;
      case (state_q)
         IDLE: begin
            pw_d = PW_CLOSED;
            if (pend != '0 && !bus.cancel) state_d = ARM;
         end
         ARM: begin
            if (bus.cancel) begin
               state_d = IDLE;
            end else if (bus.frame_tick) begin
               pw_d    = PW_OPEN;
               cnt_d   = '0;
               dec     = 1'b1;
               state_d = OPEN;
            end
         end
         OPEN: begin
            if (bus.cancel) abort_d = 1'b1;
            // A cancel coincident with a tick closes on that same tick.
            if (bus.frame_tick) begin
               if (abort_q || bus.cancel || cnt_q == OPEN_LAST) begin
                  pw_d    = PW_CLOSED;
                  cnt_d   = '0;
                  abort_d = 1'b0;
                  state_d = CLOSE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         CLOSE: begin
            if (bus.frame_tick) begin
               if (cnt_q == CLOSE_LAST) begin
                  done_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pw_q    <= PW_CLOSED;
         abort_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pw_q    <= pw_d;
         abort_q <= abort_d;
         done_q  <= done_d;
      end
   end

   assign bus.pulse_width = pw_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.pending     = pend;
   assign bus.done        = done_q;
   assign bus.overflow    = ovf;

endmodule

// File: tb/tb_servo_seq.sv
// Bench for servo_seq: vector table, frame-level scenarios and random traffic vs a tick-countdown model.
module tb_servo_seq;
   import servo_pkg::*;

   localparam int CW = 150000;
   localparam int OW = 60000;
   localparam int OF = 50;
   localparam int CF = 25;
   localparam int MP = 15;

   localparam int PH_IDLE = 0, PH_WAIT = 1, PH_OPEN = 2, PH_SETTLE = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   servo_seq_if bus();

   servo_seq #(
      .CLOSED_W(CW), .OPEN_W(OW), .OPEN_FRAMES(OF), .CLOSE_FRAMES(CF), .MAX_PEND(MP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_ticks = 0;

   // Reference model: phase plus frames remaining in that phase.
   int m_phase, m_left, m_pend, m_pw;
   bit m_ovf, m_done;

   typedef struct {
      bit rs, r, c, t;
      int pend;
      bit busy;
      int pw;
      bit done;
      bit ovf;
   } vec_t;
   vec_t tbl[21];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit c, input bit t, input bit rs);
      bit dec;
      if (rs) begin
         m_phase = PH_IDLE; m_left = 0; m_pend = 0; m_pw = CW; m_ovf = 0; m_done = 0;
         return;
      end
      dec    = (m_phase == PH_WAIT) && t && !c;
      m_done = 0;
      case (m_phase)
         PH_IDLE:  if (m_pend > 0 && !c) m_phase = PH_WAIT;
         PH_WAIT: begin
            if (c) m_phase = PH_IDLE;
            else if (t) begin m_phase = PH_OPEN; m_left = OF; m_pw = OW; end
         end
         PH_OPEN: begin
            if (c) m_left = 1;
            if (t) begin
               m_left--;
               if (m_left == 0) begin m_phase = PH_SETTLE; m_left = CF; m_pw = CW; end
            end
         end
         default: begin
            if (t) begin
               m_left--;
               if (m_left == 0) begin m_phase = PH_IDLE; m_done = 1; end
            end
         end
      endcase
      if (c) m_pend = 0;
      else if (r && dec) m_pend = m_pend;
      else if (r) begin
         if (m_pend == MP) m_ovf = 1;
         else m_pend++;
      end else if (dec) m_pend--;
   endtask

   task automatic cyc(input bit r, input bit c, input bit t, input bit rs = 0);
      bus.req = r; bus.cancel = c; bus.frame_tick = t; rst = rs;
      @(posedge clk);
      model_step(r, c, t, rs);
      if (t) n_ticks++;
      #1;
      chk("pulse_width", bus.pulse_width, m_pw);
      chk("busy", bus.busy, (m_phase != PH_IDLE));
      chk("pending", bus.pending, m_pend);
      chk("done", bus.done, m_done);
      chk("overflow", bus.overflow, m_ovf);
   endtask

   // Tick every 20 cycles until the queue drains; report tick indices of width edges.
   task automatic run_frames(input int max_cyc, output int k_open, output int k_close,
                             output int k_done, output int n_done, output int idle_gaps);
      int tcnt;
      bit seen_busy, fin, tk;
      int prev_pw;
      tcnt = 0; seen_busy = 0; fin = 0;
      k_open = -1; k_close = -1; k_done = -1; n_done = 0; idle_gaps = 0;
      for (int i = 0; i < max_cyc && !fin; i++) begin
         tk = (tcnt == 19);
         tcnt = tk ? 0 : tcnt + 1;
         prev_pw = int'(bus.pulse_width);
         cyc(0, 0, tk);
         if (tk && k_open < 0 && bus.pulse_width == OW && prev_pw != OW) k_open = n_ticks;
         if (tk && k_close < 0 && bus.pulse_width == CW && prev_pw == OW) k_close = n_ticks;
         if (bus.done) begin
            n_done++;
            if (k_done < 0) k_done = n_ticks;
         end
         if (bus.busy) seen_busy = 1;
         else if (seen_busy && bus.pending != 0) idle_gaps++;
         if (seen_busy && !bus.busy && bus.pending == 0) fin = 1;
      end
      chk("run_frames finished within budget", fin, 1);
   endtask

   task automatic idle_then_tick(input int n);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 19; j++) cyc(0, 0, 0);
         cyc(0, 0, 1);
      end
   endtask

   initial begin
      int ko, kc, kd, nd, ig;
      bit r, c, t, rs;

      bus.req = 0; bus.cancel = 0; bus.frame_tick = 0;

      tbl[0]  = '{1,0,0,0, 0,0,CW,0,0};
      tbl[1]  = '{0,1,0,0, 1,0,CW,0,0};
      tbl[2]  = '{0,0,0,0, 1,1,CW,0,0};
      tbl[3]  = '{0,0,0,1, 0,1,OW,0,0};
      tbl[4]  = '{0,1,0,0, 1,1,OW,0,0};
      tbl[5]  = '{0,0,1,0, 0,1,OW,0,0};
      tbl[6]  = '{0,1,1,0, 0,1,OW,0,0};
      tbl[7]  = '{0,0,0,1, 0,1,CW,0,0};
      tbl[8]  = '{1,0,0,0, 0,0,CW,0,0};
      tbl[9]  = '{0,1,1,0, 0,0,CW,0,0};
      tbl[10] = '{0,1,0,0, 1,0,CW,0,0};
      tbl[11] = '{0,0,1,0, 0,0,CW,0,0};
      tbl[12] = '{0,0,0,0, 0,0,CW,0,0};
      tbl[13] = '{0,1,0,0, 1,0,CW,0,0};
      tbl[14] = '{0,0,0,0, 1,1,CW,0,0};
      tbl[15] = '{0,0,1,0, 0,0,CW,0,0};
      tbl[16] = '{0,0,0,1, 0,0,CW,0,0};
      tbl[17] = '{0,1,0,0, 1,0,CW,0,0};
      tbl[18] = '{0,0,0,1, 1,1,CW,0,0};
      tbl[19] = '{0,0,0,1, 0,1,OW,0,0};
      tbl[20] = '{1,0,0,0, 0,0,CW,0,0};

      for (int i = 0; i < 21; i++) begin
         cyc(tbl[i].r, tbl[i].c, tbl[i].t, tbl[i].rs);
         chk($sformatf("vec%0d pending", i), bus.pending, tbl[i].pend);
         chk($sformatf("vec%0d busy", i), bus.busy, tbl[i].busy);
         chk($sformatf("vec%0d pulse_width", i), bus.pulse_width, tbl[i].pw);
         chk($sformatf("vec%0d done", i), bus.done, tbl[i].done);
         chk($sformatf("vec%0d overflow", i), bus.overflow, tbl[i].ovf);
      end

      // Single request through a full open/close cycle.
      cyc(0, 0, 0, 1);
      n_ticks = 0;
      cyc(1, 0, 0);
      chk("single pending after req", bus.pending, 1);
      run_frames(4000, ko, kc, kd, nd, ig);
      chk("single open tick", ko, 1);
      chk("single close tick", kc, 1 + OF);
      chk("single done tick", kd, 1 + OF + CF);
      chk("single done count", nd, 1);
      chk("single pending end", bus.pending, 0);

      // Three back-to-back requests.
      cyc(0, 0, 0, 1);
      n_ticks = 0;
      cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
      chk("triple pending", bus.pending, 3);
      run_frames(12000, ko, kc, kd, nd, ig);
      chk("triple done count", nd, 3);
      chk("triple idle gaps", ig, 2);
      chk("triple pending end", bus.pending, 0);

      // Saturation while busy, then reset mid-OPEN.
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
      chk("sat in open", bus.pulse_width, OW);
      for (int i = 0; i < 16; i++) cyc(1, 0, 0);
      chk("sat pending", bus.pending, 15);
      chk("sat overflow", bus.overflow, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0);
      chk("sat overflow sticky", bus.overflow, 1);
      cyc(0, 1, 0);
      chk("cancel clears pending", bus.pending, 0);
      chk("cancel keeps overflow", bus.overflow, 1);
      cyc(0, 0, 0, 1);
      chk("rst pulse_width", bus.pulse_width, CW);
      chk("rst busy", bus.busy, 0);
      chk("rst pending", bus.pending, 0);
      chk("rst overflow", bus.overflow, 0);
      chk("rst done", bus.done, 0);

      // Cancel at OPEN frame 10.
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
      idle_then_tick(10);
      cyc(0, 1, 0);
      chk("abort holds width until tick", bus.pulse_width, OW);
      n_ticks = 0;
      run_frames(2000, ko, kc, kd, nd, ig);
      chk("abort close tick", kc, 1);
      chk("abort done tick", kd, 1 + CF);
      chk("abort done count", nd, 1);
      chk("abort pending", bus.pending, 0);

      // Random traffic against the model.
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 8000; i++) begin
         t  = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 15) == 0);
         c  = !t && ($urandom_range(0, 149) == 0);
         rs = ($urandom_range(0, 2999) == 0);
         cyc(r, c, t, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
